i2c_txn_sequencer: RTL

Synthesizable I2C transaction controller that arbitrates register-access requests from NREQ on-chip requesters and sequences a byte-level I2C engine through the START/address/index/data/RESTART/STOP steps of each transaction. It sits between the register clients (host bridge, auto-poller, ...) and the single I2C byte engine that drives SDA/SCL. It hides bus protocol order, NACK recovery and engine timeouts from the clients.

---
 rtl/i2c_txn_sequencer_if.sv | 42 ++++
 rtl/i2c_txn_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_sequencer_if.sv
`default_nettype none
// ------------------------------------------------------------------------------------
// i2c_txn_sequencer_if: requester, response and byte-engine bundle -- rev 1.0
// ------------------------------------------------------------------------------------
interface i2c_txn_sequencer_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_rw;
  logic [7*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_index;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   req_gnt;
  logic              rsp_valid;
  logic [2:0]        rsp_id;
  logic [7:0]        rsp_rdata;
  logic [1:0]        rsp_err;
  logic              busy;
  logic [2:0]        eng_cmd;
  logic [7:0]        eng_wdata;
  logic              eng_valid;
  logic              eng_ready;
  logic              eng_done;
  logic              eng_ack_n;
  logic [7:0]        eng_rdata;
  logic              eng_abort;

  modport slave (
    input  req_valid, req_rw, req_addr, req_index, req_wdata,
           eng_ready, eng_done, eng_ack_n, eng_rdata,
    output req_gnt, rsp_valid, rsp_id, rsp_rdata, rsp_err, busy,
           eng_cmd, eng_wdata, eng_valid, eng_abort
  );

  modport master (
    output req_valid, req_rw, req_addr, req_index, req_wdata,
           eng_ready, eng_done, eng_ack_n, eng_rdata,
    input  req_gnt, rsp_valid, rsp_id, rsp_rdata, rsp_err, busy,
           eng_cmd, eng_wdata, eng_valid, eng_abort
  );
endinterface
`default_nettype wire

// File: rtl/i2c_txn_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------------------------
// i2c_txn_sequencer: round-robin request arbiter driving an I2C byte engine -- rev 1.0
// ------------------------------------------------------------------------------------
module i2c_txn_sequencer #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 4096
) (
  input  wire logic          clk,
  input  wire logic          rst,
  i2c_txn_sequencer_if.slave bus
);
  localparam int              TW           = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   C_TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0]      C_LAST_ID    = 3'(NREQ - 1);
  localparam logic [2:0]      C_CMD_START  = 3'd0;
  localparam logic [2:0]      C_CMD_WRITE  = 3'd1;
  localparam logic [2:0]      C_CMD_READ   = 3'd2;
  localparam logic [2:0]      C_CMD_RESTART = 3'd3;
  localparam logic [2:0]      C_CMD_STOP   = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t         r_state;
  logic [2:0]     r_last_grant;
  logic [2:0]     r_id;
  logic [2:0]     r_step;
  logic           r_rw;
  logic [6:0]     r_addr;
  logic [7:0]     r_index;
  logic [7:0]     r_wdata;
  logic [7:0]     r_rdata;
  logic [1:0]     r_err;
  logic [TW-1:0]  r_timer;

  logic            w_any;
  logic [2:0]      w_win;
  int              w_dist;
  int              w_best;
  logic [NREQ-1:0] w_gnt;
  logic            w_rw;
  logic [6:0]      w_addr;
  logic [7:0]      w_index;
  logic [7:0]      w_wdata;
  logic            w_nack;
  logic [2:0]      w_next_step;

  // Write: START, W{a,0}, W idx, W data, STOP.  Read: START, W{a,0}, W idx, RESTART, W{a,1}, READ_NACK, STOP.
  function automatic logic [2:0] cmd_of(input logic is_rd, input logic [2:0] s);
    logic [2:0] c;
    c = C_CMD_WRITE;
    if (s == 3'd0) c = C_CMD_START;
    else if (is_rd) begin
      if (s == 3'd3)      c = C_CMD_RESTART;
      else if (s == 3'd5) c = C_CMD_READ;
      else if (s == 3'd6) c = C_CMD_STOP;
    end else if (s == 3'd4) c = C_CMD_STOP;
    return c;
  endfunction

  function automatic logic [7:0] wdata_of(input logic is_rd, input logic [2:0] s, input logic [6:0] a,
                                          input logic [7:0] ix, input logic [7:0] wd);
    logic [7:0] d;
    d = 8'h00;
    case (s)
      3'd1:    d = {a, 1'b0};
      3'd2:    d = ix;
      3'd3:    d = is_rd ? 8'h00 : wd;
      3'd4:    d = is_rd ? {a, 1'b1} : 8'h00;
      default: d = 8'h00;
    endcase
    return d;
  endfunction

  // Distance 0 is the requester just after the last grant, so the lowest distance wins.
  always_comb begin
    w_any   = 1'b0;
    w_win   = 3'd0;
    w_best  = NREQ;
    w_dist  = 0;
    w_gnt   = '0;
    w_rw    = 1'b0;
    w_addr  = 7'h00;
    w_index = 8'h00;
    w_wdata = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i + NREQ - 1 - int'(r_last_grant)) % NREQ;
      if (bus.req_valid[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_win  = 3'(i);
        w_any  = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == 3'(i)) begin
        w_rw    = bus.req_rw[i];
        w_addr  = bus.req_addr[7*i +: 7];
        w_index = bus.req_index[8*i +: 8];
        w_wdata = bus.req_wdata[8*i +: 8];
      end
      w_gnt[i] = w_any && (w_win == 3'(i)) && (r_state == S_IDLE) && !rst;
    end
  end

  assign w_nack      = (bus.eng_cmd == C_CMD_WRITE) && bus.eng_ack_n;
  assign w_next_step = w_nack ? (r_rw ? 3'd6 : 3'd4) : (r_step + 3'd1);

  assign bus.req_gnt = w_gnt;
  assign bus.busy    = (r_state != S_IDLE) || (|w_gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_last_grant  <= C_LAST_ID;
      r_id          <= 3'd0;
      r_step        <= 3'd0;
      r_rw          <= 1'b0;
      r_addr        <= 7'h00;
      r_index       <= 8'h00;
      r_wdata       <= 8'h00;
      r_rdata       <= 8'h00;
      r_err         <= 2'b00;
      r_timer       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 3'd0;
      bus.rsp_rdata <= 8'h00;
      bus.rsp_err   <= 2'b00;
      bus.eng_cmd   <= 3'd0;
      bus.eng_wdata <= 8'h00;
      bus.eng_valid <= 1'b0;
      bus.eng_abort <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_rw          <= w_rw;
            r_addr        <= w_addr;
            r_index       <= w_index;
            r_wdata       <= w_wdata;
            r_id          <= w_win;
            r_step        <= 3'd0;
            r_err         <= 2'b00;
            r_rdata       <= 8'h00;
            bus.eng_cmd   <= C_CMD_START;
            bus.eng_wdata <= 8'h00;
            bus.eng_valid <= 1'b1;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.eng_ready) begin
            bus.eng_valid <= 1'b0;
            r_timer       <= '0;
            r_state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.eng_done) begin
            if (bus.eng_cmd == C_CMD_STOP) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_id    <= r_id;
              bus.rsp_err   <= r_err;
              bus.rsp_rdata <= (r_rw && (r_err == 2'b00)) ? r_rdata : 8'h00;
              r_state       <= S_RESP;
            end else begin
              if (w_nack && (r_err == 2'b00)) r_err <= 2'b01;
              if (bus.eng_cmd == C_CMD_READ) r_rdata <= bus.eng_rdata;
              r_step        <= w_next_step;
              bus.eng_cmd   <= cmd_of(r_rw, w_next_step);
              bus.eng_wdata <= wdata_of(r_rw, w_next_step, r_addr, r_index, r_wdata);
              bus.eng_valid <= 1'b1;
              r_state       <= S_ISSUE;
            end
          end else if (r_timer == C_TIMER_LAST) begin
            // Stuck engine: abort it and report without attempting a STOP.
            bus.eng_abort <= 1'b1;
            if (r_err == 2'b00) r_err <= 2'b10;
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= r_id;
            bus.rsp_err   <= (r_err == 2'b00) ? 2'b10 : r_err;
            bus.rsp_rdata <= 8'h00;
            r_state       <= S_RESP;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_RESP: begin
          bus.rsp_valid <= 1'b0;
          bus.rsp_id    <= 3'd0;
          bus.rsp_rdata <= 8'h00;
          bus.rsp_err   <= 2'b00;
          bus.eng_abort <= 1'b0;
          r_last_grant  <= r_id;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
